// File: rtl/shift_rot_sequencer.sv
// Command sequencer for an external bidirectional rotate register: loads a pattern,
// rotates it cmd_count times, returns the result, and otherwise freezes the register.
module shift_rot_sequencer #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic             cmd_dir,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [WIDTH-1:0] sr_q,
    output logic             load,
    output logic             shift_dir,
    output logic [WIDTH-1:0] data_in,
    output logic             busy,
    output logic [WIDTH-1:0] result_data,
    output logic             result_valid
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] pat_q;
    logic             dir_q;
    logic [CNT_W-1:0] cnt_q;
    logic             accept;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = LOAD;
            LOAD:  state_nxt = (cnt_q != '0) ? SHIFT : DONE;
            // cnt_q counts remaining steps, so leave when the last one is in flight
            SHIFT: if (cnt_q == CNT_W'(1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outside LOAD/SHIFT the register reloads its own output, which freezes it.
    always_comb begin
        load      = 1'b1;
        shift_dir = 1'b0;
        data_in   = sr_q;
        case (state)
            LOAD: begin
                load      = 1'b1;
                shift_dir = dir_q;
                data_in   = pat_q;
            end
            SHIFT: begin
                load      = 1'b0;
                shift_dir = dir_q;
                data_in   = pat_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pat_q <= '0;
            dir_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            pat_q <= cmd_data;
            dir_q <= cmd_dir;
            cnt_q <= cmd_count;
        end else if (state == SHIFT) begin
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            result_data  <= '0;
            result_valid <= 1'b0;
        end else begin
            result_valid <= (state == DONE);
            if (state == DONE) result_data <= sr_q;
        end
    end

endmodule

// File: tb/tb_shift_rot_sequencer.sv
// Bench for shift_rot_sequencer: models the downstream rotate register and checks
// results and timing against an arithmetic rotation reference.
module tb_shift_rot_sequencer;

    localparam int W = 4;
    localparam int C = 4;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_dir = 1'b0;
    logic [C-1:0] cmd_count = '0;
    logic [W-1:0] sr_q;
    logic         load;
    logic         shift_dir;
    logic [W-1:0] data_in;
    logic         busy;
    logic [W-1:0] result_data;
    logic         result_valid;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    shift_rot_sequencer #(.WIDTH(W), .CNT_W(C)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_data(cmd_data), .cmd_dir(cmd_dir), .cmd_count(cmd_count),
        .sr_q(sr_q), .load(load), .shift_dir(shift_dir), .data_in(data_in),
        .busy(busy), .result_data(result_data), .result_valid(result_valid)
    );

    // downstream rotate register; its reset is the inverted reset_n
    logic [W-1:0] sr;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)      sr <= '0;
        else if (load)     sr <= data_in;
        else if (shift_dir) sr <= {sr[W-2:0], sr[W-1]};
        else               sr <= {sr[0], sr[W-1:1]};
    end
    assign sr_q = sr;

    function automatic logic [W-1:0] rot_ref(input logic [W-1:0] p, input logic d, input int n);
        int k, v, r;
        k = n % W;
        v = int'(p);
        if (d) r = ((v << k) | (v >> (W - k))) & ((1 << W) - 1);
        else   r = ((v >> k) | (v << (W - k))) & ((1 << W) - 1);
        return W'(r);
    endfunction

    // Issues one command and checks busy per cycle, single result_valid at N+3, and result.
    task automatic do_cmd(input logic [W-1:0] p, input logic d, input logic [C-1:0] n, input string tag);
        logic [W-1:0] exp;
        int vcnt, vcyc, nn;
        nn = int'(n);
        exp = rot_ref(p, d, nn);
        @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL %s ready_before: got %b want 1", tag, cmd_ready);
        end
        cmd_valid = 1'b1; cmd_data = p; cmd_dir = d; cmd_count = n;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_data = $urandom; cmd_dir = $urandom; cmd_count = $urandom;
        vcnt = 0; vcyc = -1;
        for (int k = 1; k <= nn + 6; k++) begin
            if (result_valid === 1'b1) begin vcnt++; vcyc = k; end
            n_cmp++;
            if (busy !== (k <= nn + 2)) begin
                n_err++; $display("FAIL %s busy_c%0d: got %b want %b", tag, k, busy, (k <= nn + 2));
            end
            if (k < nn + 6) @(negedge clk);
        end
        n_cmp++;
        if (vcnt != 1 || vcyc != nn + 3) begin
            n_err++; $display("FAIL %s valid_timing: got %0d pulses last at c%0d want 1 at c%0d", tag, vcnt, vcyc, nn + 3);
        end
        n_cmp++;
        if (result_data !== exp) begin
            n_err++; $display("FAIL %s result: got %b want %b", tag, result_data, exp);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({cmd_ready, busy, result_valid, load, shift_dir} !== 5'b10010 || result_data !== '0 || data_in !== '0) begin
            n_err++; $display("FAIL reset_state: got rdy%b bsy%b rv%b ld%b sd%b rd%b di%b want 1 0 0 1 0 0000 0000",
                              cmd_ready, busy, result_valid, load, shift_dir, result_data, data_in);
        end
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_directed;
        do_cmd(4'b0001, 1'b1, 4'd1,  "left1");
        do_cmd(4'b1000, 1'b0, 4'd3,  "right3");
        do_cmd(4'b1011, 1'b1, 4'd0,  "count0");
        do_cmd(4'b1011, 1'b0, 4'd4,  "count4");
        do_cmd(4'b0001, 1'b1, 4'd15, "count15");
    endtask

    task automatic test_back_to_back;
        logic [W-1:0] pa, pb, ea;
        logic da, db;
        logic [C-1:0] na, nb;
        int extra;
        pa = 4'b0110; da = 1'b1; na = 4'd2;
        pb = 4'b1001; db = 1'b0; nb = 4'd5;
        ea = rot_ref(pa, da, int'(na));
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = pa; cmd_dir = da; cmd_count = na;
        @(posedge clk);
        @(negedge clk);
        cmd_data = pb; cmd_dir = db; cmd_count = nb;
        extra = 0;
        for (int k = 1; k < int'(na) + 3; k++) begin
            if (result_valid === 1'b1) extra++;
            @(negedge clk);
        end
        n_cmp++;
        if (extra != 0) begin
            n_err++; $display("FAIL b2b_early_valid: got %0d pulses want 0", extra);
        end
        n_cmp++;
        if (result_valid !== 1'b1 || cmd_ready !== 1'b1 || result_data !== ea) begin
            n_err++; $display("FAIL b2b_first: got rv%b rdy%b rd%b want rv1 rdy1 rd%b", result_valid, cmd_ready, result_data, ea);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (busy !== 1'b1 || result_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_second_accept: got busy%b rv%b want busy1 rv0", busy, result_valid);
        end
        for (int k = 2; k <= int'(nb) + 3; k++) @(negedge clk);
        n_cmp++;
        if (result_valid !== 1'b1 || result_data !== rot_ref(pb, db, int'(nb))) begin
            n_err++; $display("FAIL b2b_second: got rv%b rd%b want rv1 rd%b", result_valid, result_data, rot_ref(pb, db, int'(nb)));
        end
        @(negedge clk);
    endtask

    task automatic test_hold;
        logic [W-1:0] s0, r0;
        int bad;
        do_cmd(4'b0101, 1'b1, 4'd3, "hold_cmd");
        s0 = sr_q; r0 = result_data; bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (sr_q !== s0 || result_data !== r0 || load !== 1'b1 || result_valid !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_err++; $display("FAIL hold: got %0d disturbed cycles want 0 (sr%b rd%b)", bad, sr_q, result_data);
        end
        n_cmp++;
        if (sr_q !== 4'b1010) begin
            n_err++; $display("FAIL hold_value: got %b want 1010", sr_q);
        end
    endtask

    task automatic test_reset_mid_shift;
        int pulses;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_data = 4'b0011; cmd_dir = 1'b1; cmd_count = 4'd7;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, busy, result_valid, load} !== 4'b1001 || result_data !== '0) begin
            n_err++; $display("FAIL midreset_state: got rdy%b bsy%b rv%b ld%b rd%b want 1 0 0 1 0000",
                              cmd_ready, busy, result_valid, load, result_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (result_valid === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || busy !== 1'b0) begin
            n_err++; $display("FAIL midreset_abort: got %0d pulses busy%b want 0 busy0", pulses, busy);
        end
        do_cmd(4'b0011, 1'b1, 4'd7, "after_reset");
    endtask

    task automatic test_random;
        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_cmd(W'($urandom), 1'($urandom), C'($urandom), $sformatf("rand%0d", i));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_reset_mid_shift();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
